uart_tx_param: RTL
==================

Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 sender used in the single-cycle CPU's peripheral bus.
- Baud timing comes from an internal divider of sysclk; no separate baud clock.
- Configurable data width, parity and stop bits.
- Small TX FIFO, so the CPU can queue several bytes and frames go out back-to-back.
- Sits between the memory-mapped UART register block and the board UART_TX pin.

Parameters:
CLK_FREQ, 100000000, sysclk frequency in Hz
BAUD, 9600, line rate in bit/s; DIV = CLK_FREQ/BAUD (integer division), must be >= 2
DATA_BITS, 8, payload bits per frame, range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, TX queue entries, power of 2, >= 2

Ports:
sysclk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
TX_EN  in  1  write strobe; TX_DATA is enqueued on any edge where TX_EN=1 and TX_STATUS=1
TX_DATA  in  DATA_BITS  payload to enqueue
TX_STATUS  out  1  1 = FIFO not full, ready to accept a write
TX_BUSY  out  1  1 = frame in progress or FIFO non-empty
TX_OVERRUN  out  1  one-cycle pulse when TX_EN=1 is presented while TX_STATUS=0
FIFO_COUNT  out  log2(FIFO_DEPTH)+1  entries currently queued
UART_TX  out  1  serial line, idle high

Behaviour:
- Reset values: UART_TX=1, TX_STATUS=1, TX_BUSY=0, TX_OVERRUN=0, FIFO_COUNT=0; FSM=IDLE; baud counter=0; FIFO pointers=0.
- Reset mid-frame aborts the frame. UART_TX is 1 after the reset edge; queued data is discarded.
- All outputs are registered.
- FIFO:
  - Write when TX_EN & TX_STATUS. Pop only by the FSM.
  - Simultaneous write and pop when not full: FIFO_COUNT is unchanged.
  - When full, a write is refused even if a pop occurs in the same cycle; TX_OVERRUN pulses and the data is dropped.
  - Pointers wrap modulo FIFO_DEPTH.
  - TX_STATUS = (FIFO_COUNT != FIFO_DEPTH), updated on the same edge as FIFO_COUNT.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If FIFO non-empty: pop head into the shift register, compute parity, drive UART_TX=0, reset baud counter, go to START.
  - Latency: TX_EN sampled at edge k into an empty FIFO gives UART_TX=0 after edge k+1.
- Every bit is held for exactly DIV sysclk cycles. The baud counter runs 0..DIV-1; the bit boundary is at DIV-1.
- START -> DATA. DATA shifts out DATA_BITS bits, LSB first.
- After the last data bit: go to PARITY if PARITY != 0, else STOP.
- Parity bit value:
  - odd: ~^data
  - even: ^data
- STOP drives UART_TX=1 for STOP_BITS*DIV cycles.
- At the end of STOP:
  - If FIFO non-empty: start the next START bit on the same edge, with no idle gap.
  - Otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV cycles.
- TX_BUSY = (state != IDLE) | (FIFO_COUNT != 0).
- TX_DATA changes after enqueue have no effect on the frame in flight.

Test Plan:
- Reset, then TX_EN=1 with TX_DATA=8'hA5 for one cycle (CLK_FREQ=160000, BAUD=10000, DIV=16, 8N1) -> UART_TX low after next edge for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high. TX_BUSY deasserts exactly 160 cycles after the start edge.
- PARITY=2, data 8'h07; then PARITY=1, same data -> parity bit 1 (even), then 0 (odd). STOP_BITS=2 -> line high for 32 cycles before IDLE.
- Write 4 bytes 0x11,0x22,0x33,0x44 on consecutive cycles (FIFO_DEPTH=4) -> FIFO_COUNT peaks at 3, TX_STATUS stays 1 (one entry popped on 2nd edge). Four frames go out contiguous, start bit immediately after each stop bit.
- Fill FIFO while a frame is active, then TX_EN with 0xFF -> TX_OVERRUN pulses 1 cycle, FIFO_COUNT stays 4, 0xFF never appears on the line.
- Assert reset at cycle 50 of a frame -> UART_TX=1 next edge, FIFO_COUNT=0, TX_BUSY=0, no further transitions.
- DATA_BITS=5, data 5'b10011 -> exactly 5 data bits 1,1,0,0,1, frame = 7*DIV cycles.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with an internal baud divider and a small TX queue.
// Frames leave back-to-back while the queue holds data; every output is registered.
module uart_tx_param #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          TX_EN,
  input  logic [DATA_BITS-1:0]          TX_DATA,
  output logic                          TX_STATUS,
  output logic                          TX_BUSY,
  output logic                          TX_OVERRUN,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          UART_TX
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count_nxt;
  logic                 tick;
  logic                 push;
  logic                 pop;
  logic                 tx_nxt;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  assign tick = (baud_cnt == DIV_LAST);
  // A full queue refuses the write even when the FSM pops on the same edge.
  assign push = TX_EN & TX_STATUS;

  always_comb begin
    count_nxt = FIFO_COUNT;
    if (push && !pop) begin
      count_nxt = FIFO_COUNT + (AW + 1)'(1);
    end else if (pop && !push) begin
      count_nxt = FIFO_COUNT - (AW + 1)'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_nxt    = UART_TX;
    unique case (state)
      S_IDLE: begin
        if (FIFO_COUNT != '0) begin
          pop       = 1'b1;
          tx_nxt    = 1'b0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          tx_nxt    = shreg[0];
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt == BIT_LAST) begin
            if (PARITY != 0) begin
              tx_nxt    = par_bit;
              state_nxt = S_PARITY;
            end else begin
              tx_nxt    = 1'b1;
              state_nxt = S_STOP;
            end
          end else begin
            tx_nxt = shreg[0];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          tx_nxt    = 1'b1;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        // Chain straight into the next start bit so queued frames have no idle gap.
        if (tick && (stop_cnt == STOP_LAST)) begin
          if (FIFO_COUNT != '0) begin
            pop       = 1'b1;
            tx_nxt    = 1'b0;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_COUNT <= '0;
      TX_STATUS  <= 1'b1;
      TX_BUSY    <= 1'b0;
      TX_OVERRUN <= 1'b0;
      UART_TX    <= 1'b1;
    end else begin
      baud_cnt   <= ((state == S_IDLE) || tick) ? '0 : baud_cnt + CW'(1);
      bit_cnt    <= (state != S_DATA) ? '0 : (tick ? bit_cnt + BW'(1) : bit_cnt);
      stop_cnt   <= (state != S_STOP) ? 1'b0 : (stop_cnt ^ tick);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      FIFO_COUNT <= count_nxt;
      TX_STATUS  <= (count_nxt != FULL);
      TX_BUSY    <= (state_nxt != S_IDLE) || (count_nxt != '0);
      TX_OVERRUN <= TX_EN & ~TX_STATUS;
      UART_TX    <= tx_nxt;
    end
  end

  // Payload storage and shifter carry no reset; pointers and state qualify them.
  always_ff @(posedge sysclk) begin
    if (push) begin
      mem[wr_ptr] <= TX_DATA;
    end
    if (pop) begin
      shreg   <= mem[rd_ptr];
      par_bit <= calc_parity(mem[rd_ptr]);
    end else if (((state == S_START) || (state == S_DATA)) && tick) begin
      shreg <= shreg >> 1;
    end
  end

endmodule
